// File: rtl/scan_encoder_pkg.sv
// rtl/scan_encoder_pkg.sv - shared types and helpers for scan_encoder
package scan_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int MAX_W = 256;

    // True when at most one bit is set; callers zero-extend their vector to MAX_W.
    function automatic logic at_most_one(input logic [MAX_W-1:0] v);
        return (v & (v - MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/scan_encoder_pick.sv
// rtl/scan_encoder_pick.sv - first-set-bit finder; SCAN_ENCODER_MSB_FIRST_EN selects highest-first order
module scan_encoder_pick #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |vec;
`ifdef SCAN_ENCODER_MSB_FIRST_EN
        // Ascending walk: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = i[IDX_W-1:0];
        end
`else
        // Descending walk: the last hit, i.e. the lowest set bit, wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[IDX_W-1:0];
        end
`endif
    end

endmodule

// File: rtl/scan_encoder.sv
// rtl/scan_encoder.sv - sequential bit-scan encoder, one index per beat (order via SCAN_ENCODER_MSB_FIRST_EN)
module scan_encoder
    import scan_encoder_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    if (WIDTH < 2 || WIDTH > MAX_W) begin : g_width_check
        $error("scan_encoder: WIDTH out of range");
    end

    scan_state_e      state, state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] one_hot;
    logic [WIDTH-1:0] load_vec;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             advance;
    logic             finish;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign accept    = in_valid & in_ready;
    assign advance   = out_valid & out_ready & ~out_last;
    assign finish    = out_valid & out_ready & out_last;

    always_comb begin
        one_hot          = '0;
        one_hot[out_idx] = 1'b1;
    end

    // In IDLE the next beat comes from the new vector, otherwise from pending minus the reported bit.
    assign load_vec = (state == IDLE) ? in_data : (pending & ~one_hot);

    scan_encoder_pick #(
        .WIDTH(WIDTH)
    ) u_pick (
        .vec(load_vec),
        .idx(pick_idx),
        .any(pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_zero <= 1'b0;
        end else if (accept || advance) begin
            pending  <= load_vec;
            out_idx  <= pick_idx;
            out_last <= at_most_one(MAX_W'(load_vec));
            out_zero <= ~pick_any;
        end else if (finish) begin
            pending  <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_encoder.sv
// tb/tb_scan_encoder.sv - self-checking bench for scan_encoder (honours SCAN_ENCODER_MSB_FIRST_EN)
module tb_scan_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_zero;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    typedef struct {
        logic [15:0] data;
        int          lsb_first;
        int          msb_first;
        int          nbeats;
    } vec_t;

    vec_t tbl[7];

    scan_encoder #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx(out_idx),
        .out_last(out_last),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list of set-bit positions in scan order; -1 stands for the all-zero beat.
    function automatic void build_expected(input logic [15:0] d);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (d[i]) begin
`ifdef SCAN_ENCODER_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
        if (exp_q.size() == 0) exp_q.push_back(-1);
    endfunction

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},  int'(in_ready),  1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_idx"},   int'(out_idx),   0);
        check({tag, "_out_last"},  int'(out_last),  0);
        check({tag, "_out_zero"},  int'(out_zero),  0);
    endtask

    task automatic run_vec(input logic [15:0] d, input int pre_stall, input int stall_pct,
                           input bit hold, output int first, output int nbeats);
        int k;
        int cyc;
        int e;
        build_expected(d);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
        k = 0; cyc = 0; first = -1; nbeats = 0;
        while (k < exp_q.size() && cyc < 300) begin
            out_ready = (cyc < pre_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            e = exp_q[k];
            check("out_valid",     int'(out_valid), 1);
            check("in_ready_busy", int'(in_ready),  0);
            check("out_idx",       int'(out_idx),   (e < 0) ? 0 : e);
            check("out_last",      int'(out_last),  (k == exp_q.size() - 1) ? 1 : 0);
            check("out_zero",      int'(out_zero),  (e < 0) ? 1 : 0);
            if (out_valid && out_ready) begin
                if (k == 0) first = int'(out_idx);
                nbeats++;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (k < exp_q.size()) check("beat_timeout", k, exp_q.size());
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle("post_vec");
    endtask

    initial begin
        int first;
        int nb;
        logic [15:0] d;

        tbl[0] = '{16'h0112,  1,  8,  3};
        tbl[1] = '{16'h0000,  0,  0,  1};
        tbl[2] = '{16'h8000, 15, 15,  1};
        tbl[3] = '{16'hFFFF,  0, 15, 16};
        tbl[4] = '{16'h0001,  0,  0,  1};
        tbl[5] = '{16'hA5A5,  0, 15,  8};
        tbl[6] = '{16'h0180,  7,  8,  2};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_idx",   int'(out_idx),   0);
        check("rst_out_last",  int'(out_last),  0);
        check("rst_out_zero",  int'(out_zero),  0);
        @(posedge clk); #1;
        rst = 1'b0;

        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_idle("idle_ready_noeffect");

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i].data, 0, 0, 1'b0, first, nb);
`ifdef SCAN_ENCODER_MSB_FIRST_EN
            check("tbl_first", first, tbl[i].msb_first);
`else
            check("tbl_first", first, tbl[i].lsb_first);
`endif
            check("tbl_nbeats", nb, tbl[i].nbeats);
        end

        run_vec(16'h8000, 3, 0, 1'b0, first, nb);
        check("stall_first", first, 15);
        check("stall_nbeats", nb, 1);

        run_vec(16'hFFFF, 0, 0, 1'b1, first, nb);
        check("hold_nbeats", nb, 16);

        build_expected(16'h0112);
        in_valid = 1'b1; in_data = 16'h0112;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_first_idx", int'(out_idx), exp_q[0]);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_out_idx",   int'(out_idx),   0);
        check("midrst_out_last",  int'(out_last),  0);
        check("midrst_out_zero",  int'(out_zero),  0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        run_vec(16'h0004, 0, 0, 1'b0, first, nb);
        check("after_rst_first", first, 2);
        check("after_rst_nbeats", nb, 1);

        for (int r = 0; r < 80; r++) begin
            case ($urandom_range(3))
                0:       d = 16'($urandom);
                1:       d = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       d = 16'h0000;
                default: d = 16'h0001 << $urandom_range(15);
            endcase
            run_vec(d, 0, 30, 1'b0, first, nb);
            check("rnd_nbeats", nb, ($countones(d) == 0) ? 1 : $countones(d));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
